lsu_ctrl: RTL

Load/store control unit between the execute stage and the `memory` stage of the RV64 NPC core. It accepts one load or store per transaction over a valid/ready handshake and sequences the single-cycle `memory` port. For stores it builds the byte-aligned write data and `wmask`. For loads it waits the registered read cycle, sign- or zero-extends the zero-extended `mem_rdata`, and returns a tagged response to writeback.

---
 rtl/lsu_ctrl.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/lsu_ctrl.sv
// Load/store sequencer between execute and the single-cycle memory port.
// Optional misaligned-access trap is enabled with `define LSU_MISALIGN_TRAP_EN.
module lsu_ctrl #(
    parameter int WDT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [63:0]      req_addr,
    input  logic [63:0]      req_wdata,
    input  logic             req_wen,
    input  logic [1:0]       req_size,
    input  logic             req_unsigned,
    input  logic [4:0]       req_rd,
    output logic             mem_ren,
    output logic [63:0]      mem_raddr,
    output logic [63:0]      waddr,
    output logic             mem_wen,
    output logic [63:0]      mem_wdata,
    output logic [7:0]       wmask,
    output logic [WDT_W-1:0] wdt_op,
    input  logic [63:0]      mem_rdata,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [63:0]      resp_data,
    output logic [4:0]       resp_rd,
    output logic             resp_is_load,
    output logic             resp_fault
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t      state;
    logic [63:0] a_addr;
    logic [63:0] a_wdata;
    logic        a_wen;
    logic [1:0]  a_size;
    logic        a_uns;
    logic [4:0]  a_rd;
    logic        in_access;
    logic [7:0]  base_mask;

    function automatic logic [63:0] align_addr(input logic [63:0] addr, input logic [1:0] size);
        case (size)
            2'd0:    return addr;
            2'd1:    return {addr[63:1], 1'b0};
            2'd2:    return {addr[63:2], 2'b00};
            default: return {addr[63:3], 3'b000};
        endcase
    endfunction

    function automatic logic [63:0] extend(input logic [63:0] d, input logic [1:0] size, input logic uns);
        case (size)
            2'd0:    return uns ? {56'b0, d[7:0]}  : {{56{d[7]}},  d[7:0]};
            2'd1:    return uns ? {48'b0, d[15:0]} : {{48{d[15]}}, d[15:0]};
            2'd2:    return uns ? {32'b0, d[31:0]} : {{32{d[31]}}, d[31:0]};
            default: return d;
        endcase
    endfunction

`ifdef LSU_MISALIGN_TRAP_EN
    logic fault_q;

    function automatic logic misaligned(input logic [63:0] addr, input logic [1:0] size);
        case (size)
            2'd0:    return 1'b0;
            2'd1:    return addr[0];
            2'd2:    return |addr[1:0];
            default: return |addr[2:0];
        endcase
    endfunction

    assign resp_fault = fault_q;
`else
    assign resp_fault = 1'b0;
`endif

    always_comb begin
        base_mask = 8'h00;
        case (a_size)
            2'd0:    base_mask = 8'h01;
            2'd1:    base_mask = 8'h03;
            2'd2:    base_mask = 8'h0F;
            default: base_mask = 8'hFF;
        endcase
    end

    // Strobes and address/shape outputs decode from state; rst forces them all quiet.
    assign in_access = !rst && (state == ISSUE || state == WAIT);
    assign req_ready = !rst && (state == IDLE);
    assign mem_ren   = !rst && (state == ISSUE) && !a_wen;
    assign mem_wen   = !rst && (state == ISSUE) && a_wen;
    assign mem_raddr = in_access ? a_addr : 64'h0;
    assign waddr     = in_access ? {a_addr[63:3], 3'b000} : 64'h0;
    assign mem_wdata = mem_wen ? (a_wdata << {a_addr[2:0], 3'b000}) : 64'h0;
    assign wmask     = mem_wen ? (base_mask << a_addr[2:0]) : 8'h00;

    always_comb begin
        wdt_op = '0;
        if (in_access) wdt_op[a_size] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            a_addr       <= 64'h0;
            a_wdata      <= 64'h0;
            a_wen        <= 1'b0;
            a_size       <= 2'd0;
            a_uns        <= 1'b0;
            a_rd         <= 5'd0;
            resp_valid   <= 1'b0;
            resp_data    <= 64'h0;
            resp_rd      <= 5'd0;
            resp_is_load <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
            fault_q      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    a_wdata <= req_wdata;
                    a_wen   <= req_wen;
                    a_size  <= req_size;
                    a_uns   <= req_unsigned;
                    a_rd    <= req_rd;
`ifdef LSU_MISALIGN_TRAP_EN
                    a_addr  <= req_addr;
                    fault_q <= misaligned(req_addr, req_size);
                    if (misaligned(req_addr, req_size)) begin
                        state        <= RESP;
                        resp_valid   <= 1'b1;
                        resp_data    <= 64'h0;
                        resp_rd      <= req_rd;
                        resp_is_load <= !req_wen;
                    end else begin
                        state <= ISSUE;
                    end
`else
                    a_addr <= align_addr(req_addr, req_size);
                    state  <= ISSUE;
`endif
                end
                ISSUE: begin
                    if (a_wen) begin
                        state        <= RESP;
                        resp_valid   <= 1'b1;
                        resp_data    <= 64'h0;
                        resp_rd      <= a_rd;
                        resp_is_load <= 1'b0;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    state        <= RESP;
                    resp_valid   <= 1'b1;
                    resp_data    <= extend(mem_rdata, a_size, a_uns);
                    resp_rd      <= a_rd;
                    resp_is_load <= 1'b1;
                end
                RESP: if (resp_ready) begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
